cache_victim_ctrl: RTL and testbench
====================================

# cache_victim_ctrl

Per-set way-selection and miss-sequencing controller for the N-way set-associative cache. It sits directly downstream of `pseudo_lru`, consuming its `lru_idx` to choose a victim on a miss. It also sits upstream of it, producing the `load`/`mru_idx` update after every serviced access. It sequences writeback and fill over a simple request/response memory handshake and drives the data/tag array way select and write strobes.

## Interface
Parameters:
- `WAYS`, 8, associativity; power of two, at least 2; must match `pseudo_lru` size.
- `CNT_W`, 16, width of the statistics counters.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  access request; held high until `cpu_resp`.
- `cpu_write`  in  1  access is a store; sampled with `cpu_req` at acceptance.
- `hit`  in  WAYS  tag-compare match vector for the addressed set.
- `valid`  in  WAYS  per-way valid bits for the addressed set.
- `dirty`  in  WAYS  per-way dirty bits for the addressed set.
- `lru_idx`  in  $clog2(WAYS)  victim way from `pseudo_lru`.
- `load`  out  1  one-cycle PLRU update strobe.
- `mru_idx`  out  $clog2(WAYS)  way just used; qualified by `load`.
- `way_sel`  out  $clog2(WAYS)  way addressed in the data/tag arrays.
- `way_we`  out  1  one-cycle fill write strobe for the tag/data/valid arrays.
- `set_dirty`  out  1  one-cycle strobe that sets `dirty[way_sel]`.
- `mem_read`  out  1  line fill request; held until `mem_resp`.
- `mem_write`  out  1  line writeback request; held until `mem_resp`.
- `mem_resp`  in  1  memory completion, one cycle.
- `cpu_resp`  out  1  one-cycle access completion.
- `miss_cnt`  out  CNT_W  misses accepted; wraps modulo 2^CNT_W.
- `wb_cnt`  out  CNT_W  writebacks completed; wraps.

## Operation
- States: IDLE, WB, FILL, DONE.
- IDLE with `cpu_req`=0 stays in IDLE.
- IDLE with `cpu_req`=1 is acceptance. At acceptance the block samples `hit`, `valid`, `dirty`, `cpu_write` and `lru_idx` once, then ignores them until it returns to IDLE.
- Hit (`hit`≠0): `way_r` = index of lowest set bit of `hit`; more than one bit set is tolerated and the lowest index wins. Next state DONE.
- Miss (`hit`=0): the victim is the lowest-index way with `valid`=0. If all ways are valid, the victim is `lru_idx`. `way_r` = victim, `miss_cnt`+1. Next state WB if the victim is valid and dirty, else FILL.
- WB: `mem_write`=1. On `mem_resp`, `wb_cnt`+1, go to FILL.
- FILL: `mem_read`=1. On `mem_resp`, go to DONE with `fill_r`=1.
- DONE, for exactly one cycle:
  - `cpu_resp`=1, `load`=1, `mru_idx`=`way_r`.
  - `way_we`=`fill_r`.
  - `set_dirty`=`cpu_write_r`.
  - Then go to IDLE and clear `fill_r`.
- `way_sel`=`way_r` in WB, FILL and DONE, and 0 in IDLE.
- `mem_resp` in IDLE or DONE is ignored.
- `cpu_req` held across the cycle after DONE is illegal. The CPU drops `cpu_req` on the edge where it samples `cpu_resp`.

## Timing
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- Reset: state IDLE, `way_r`=0, `fill_r`=0, `cpu_write_r`=0, `miss_cnt`=0, `wb_cnt`=0. All strobes and requests are 0 in the cycle after the reset edge.
- Reset mid-operation: WB or FILL aborts, `mem_read`/`mem_write` drop at the reset edge, no `cpu_resp` is issued, and counters clear.
- Hit latency: request accepted at edge k, `cpu_resp`/`load` high in cycle k+1.
- Clean miss latency: `mem_read` high from cycle k+1. `mem_resp` sampled at edge m gives DONE in cycle m+1.
- Dirty miss: `mem_write` from cycle k+1 until the `mem_resp` edge. `mem_read` rises in the following cycle; the two requests are never high together.
- `mem_resp` coincident with the request's first cycle is accepted, giving a minimum of one cycle per memory phase.
- Counters update at the transition edge. `miss_cnt` wraps from 2^CNT_W−1 to 0.

## Test plan
- Reset then idle: after `rst` pulse, hold `cpu_req`=0 for 10 cycles -> all outputs 0, counters 0.
- Hit: `hit`=8'b0010_0000, `cpu_write`=1 -> next cycle `cpu_resp`=`load`=`set_dirty`=1, `mru_idx`=`way_sel`=5, `way_we`=0, `miss_cnt`=0.
- Cold miss: `hit`=0, `valid`=8'b0000_0111, `lru_idx`=6 -> victim 3. `mem_read` is held until `mem_resp` after 4 cycles. Then DONE with `way_we`=1, `way_sel`=3, `mru_idx`=3, `miss_cnt`=1.
- Dirty eviction: `valid`=8'hFF, `dirty`=8'h40, `lru_idx`=6 -> `mem_write` until `mem_resp`, then `mem_read` until `mem_resp`, then DONE with `way_sel`=6. `wb_cnt`=1, and the requests never overlap.
- Reset mid-fill: assert `rst` during FILL with `mem_read`=1 -> `mem_read` is 0 next cycle, state IDLE, no `cpu_resp`. A subsequent hit is serviced normally.
- Multi-hit and counter wrap: `hit`=8'b1001_0000 -> `way_sel`=4. With CNT_W=4, 16 misses -> `miss_cnt` returns to 0.

Source files
------------

// File: rtl/cache_victim_ctrl.sv
// Per-set way selection and miss sequencing: picks a hit or victim way, runs the optional
// writeback and the fill over a req/resp memory handshake, then issues one PLRU update.
module cache_victim_ctrl #(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned IDX_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_write,
  input  logic [WAYS-1:0]  hit,
  input  logic [WAYS-1:0]  valid,
  input  logic [WAYS-1:0]  dirty,
  input  logic [IDX_W-1:0] lru_idx,
  output logic             load,
  output logic [IDX_W-1:0] mru_idx,
  output logic [IDX_W-1:0] way_sel,
  output logic             way_we,
  output logic             set_dirty,
  output logic             mem_read,
  output logic             mem_write,
  input  logic             mem_resp,
  output logic             cpu_resp,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  typedef enum logic [1:0] {StIdle, StWb, StFill, StDone} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   way_q, way_d;
  logic               fill_q, fill_d;
  logic               cpu_write_q, cpu_write_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]   wb_cnt_q, wb_cnt_d;

  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W-1:0]   inv_idx;
  logic               any_inv;
  logic [IDX_W-1:0]   victim;
  logic               victim_dirty;

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    hit_idx = '0;
    inv_idx = '0;
    any_inv = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        inv_idx = IDX_W'(i);
        any_inv = 1'b1;
      end
    end
  end

  assign victim       = any_inv ? inv_idx : lru_idx;
  assign victim_dirty = valid[victim] & dirty[victim];

  always_comb begin
    state_d     = state_q;
    way_d       = way_q;
    fill_d      = fill_q;
    cpu_write_d = cpu_write_q;
    miss_cnt_d  = miss_cnt_q;
    wb_cnt_d    = wb_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          cpu_write_d = cpu_write;
          if (|hit) begin
            way_d   = hit_idx;
            state_d = StDone;
          end else begin
            way_d      = victim;
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
            state_d    = victim_dirty ? StWb : StFill;
          end
        end
      end
      StWb: begin
        if (mem_resp) begin
          wb_cnt_d = wb_cnt_q + CNT_W'(1);
          state_d  = StFill;
        end
      end
      StFill: begin
        if (mem_resp) begin
          fill_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        fill_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      way_q       <= '0;
      fill_q      <= 1'b0;
      cpu_write_q <= 1'b0;
      miss_cnt_q  <= '0;
      wb_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      way_q       <= way_d;
      fill_q      <= fill_d;
      cpu_write_q <= cpu_write_d;
      miss_cnt_q  <= miss_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
    end
  end

  // Every output decodes from registered state only.
  assign cpu_resp  = (state_q == StDone);
  assign load      = (state_q == StDone);
  assign mru_idx   = (state_q == StDone) ? way_q : '0;
  assign way_sel   = (state_q == StIdle) ? '0 : way_q;
  assign way_we    = (state_q == StDone) & fill_q;
  assign set_dirty = (state_q == StDone) & cpu_write_q;
  assign mem_write = (state_q == StWb);
  assign mem_read  = (state_q == StFill);
  assign miss_cnt  = miss_cnt_q;
  assign wb_cnt    = wb_cnt_q;

endmodule

// File: tb/tb_cache_victim_ctrl.sv
// Randomized bench for cache_victim_ctrl: a phase-queue reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cache_victim_ctrl;
  localparam int WAYS = 8;
  localparam int CNT_W = 4;
  localparam int PH_WB = 1;
  localparam int PH_FILL = 2;
  localparam int PH_DONE = 3;

  logic       clk;
  logic       rst, cpu_req, cpu_write, mem_resp;
  logic [7:0] hit, valid, dirty;
  logic [2:0] lru_idx;
  logic       load, way_we, set_dirty, mem_read, mem_write, cpu_resp;
  logic [2:0] mru_idx, way_sel;
  logic [3:0] miss_cnt, wb_cnt;

  cache_victim_ctrl #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_write(cpu_write), .hit(hit), .valid(valid),
    .dirty(dirty), .lru_idx(lru_idx), .load(load), .mru_idx(mru_idx), .way_sel(way_sel),
    .way_we(way_we), .set_dirty(set_dirty), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .cpu_resp(cpu_resp), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] f_lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [2:0] f_victim(input logic [7:0] v, input logic [2:0] l);
    for (int i = 0; i < 8; i++) if (!v[i]) return 3'(i);
    return l;
  endfunction

  // Reference model: an access becomes a queue of remaining phases.
  int         q[$];
  logic [2:0] m_way;
  logic       m_fill, m_wr;
  logic [3:0] m_miss, m_wb;

  initial begin
    m_way = 0; m_fill = 0; m_wr = 0; m_miss = 0; m_wb = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_way = 0; m_fill = 0; m_wr = 0; m_miss = 0; m_wb = 0;
      end else if (q.size() == 0) begin
        if (cpu_req) begin
          m_wr = cpu_write;
          if (hit != 0) begin
            m_way = f_lowest(hit);
            q.push_back(PH_DONE);
          end else begin
            m_miss = m_miss + 4'd1;
            m_way  = f_victim(valid, lru_idx);
            if (valid[m_way] && dirty[m_way]) q.push_back(PH_WB);
            q.push_back(PH_FILL);
            q.push_back(PH_DONE);
          end
        end
      end else if (q[0] == PH_WB) begin
        if (mem_resp) begin
          m_wb = m_wb + 4'd1;
          void'(q.pop_front());
        end
      end else if (q[0] == PH_FILL) begin
        if (mem_resp) begin
          m_fill = 1'b1;
          void'(q.pop_front());
        end
      end else begin
        m_fill = 1'b0;
        void'(q.pop_front());
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    int          head;
    logic [19:0] exp_v, act_v;
    forever begin
      @(posedge clk);
      #1;
      head  = (q.size() != 0) ? q[0] : 0;
      exp_v = {head == PH_DONE, head == PH_DONE, (head == PH_DONE) ? m_way : 3'd0,
               (head != 0) ? m_way : 3'd0, (head == PH_DONE) && m_fill,
               (head == PH_DONE) && m_wr, head == PH_FILL, head == PH_WB, m_miss, m_wb};
      act_v = {cpu_resp, load, mru_idx, way_sel, way_we, set_dirty, mem_read, mem_write,
               miss_cnt, wb_cnt};
      check("outputs_vs_model", 32'(act_v), 32'(exp_v));
      check("no_req_overlap", 32'(mem_read && mem_write), 32'd0);
    end
  end

  // Memory responder: fixed or random latency per phase, spurious pulses when idle.
  int fixed_delay = 0;
  bit rand_mode = 0;
  initial begin
    int         resp_wait;
    logic [1:0] cur, prev_ph;
    resp_wait = 0;
    prev_ph = 2'b00;
    mem_resp = 1'b0;
    forever begin
      @(negedge clk);
      cur = {mem_read, mem_write};
      if (cur != 2'b00) begin
        if (prev_ph == 2'b00 || mem_resp)
          resp_wait = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        mem_resp = (resp_wait == 0);
        resp_wait--;
      end else begin
        mem_resp = rand_mode && ($urandom_range(0, 7) == 0);
      end
      prev_ph = cur;
    end
  end

  logic       cap_resp, cap_load, cap_we, cap_sd;
  logic [2:0] cap_sel, cap_mru;
  int         cap_rd, cap_wr, cap_cyc;
  bit         cap_ovl;

  task automatic access(input logic [7:0] h, input logic [7:0] v, input logic [7:0] d,
                        input logic [2:0] l, input logic w, input bit scramble);
    @(negedge clk);
    hit = h; valid = v; dirty = d; lru_idx = l; cpu_write = w; cpu_req = 1'b1;
    cap_rd = 0; cap_wr = 0; cap_cyc = 0; cap_ovl = 0; cap_resp = 0;
    for (int c = 0; c < 100 && !cap_resp; c++) begin
      @(posedge clk);
      #1;
      cap_cyc++;
      if (scramble) begin
        hit = 8'($urandom); valid = 8'($urandom); dirty = 8'($urandom);
        lru_idx = 3'($urandom); cpu_write = 1'($urandom);
      end
      cap_rd += int'(mem_read);
      cap_wr += int'(mem_write);
      if (mem_read && mem_write) cap_ovl = 1;
      if (cpu_resp) begin
        cap_resp = 1; cap_load = load; cap_we = way_we; cap_sd = set_dirty;
        cap_sel = way_sel; cap_mru = mru_idx;
      end
    end
    check("resp_seen", 32'(cap_resp), 32'd1);
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cpu_req = 0; cpu_write = 0; hit = 0; valid = 0; dirty = 0; lru_idx = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_outputs", 32'({cpu_resp, load, mru_idx, way_sel, way_we, set_dirty, mem_read,
                               mem_write}), 32'd0);
    check("idle_miss_cnt", 32'(miss_cnt), 32'd0);
    check("idle_wb_cnt", 32'(wb_cnt), 32'd0);

    // Store hit on way 5.
    access(8'b0010_0000, 8'hFF, 8'h00, 3'd2, 1'b1, 1'b1);
    check("hit_latency", 32'(cap_cyc), 32'd1);
    check("hit_load", 32'(cap_load), 32'd1);
    check("hit_set_dirty", 32'(cap_sd), 32'd1);
    check("hit_way_sel", 32'(cap_sel), 32'd5);
    check("hit_mru", 32'(cap_mru), 32'd5);
    check("hit_way_we", 32'(cap_we), 32'd0);
    check("hit_miss_cnt", 32'(miss_cnt), 32'd0);

    // Cold miss: first invalid way is 3; fill answered in its 4th cycle.
    fixed_delay = 3;
    access(8'h00, 8'b0000_0111, 8'h00, 3'd6, 1'b0, 1'b1);
    check("cold_rd_cycles", 32'(cap_rd), 32'd4);
    check("cold_wr_cycles", 32'(cap_wr), 32'd0);
    check("cold_way_we", 32'(cap_we), 32'd1);
    check("cold_way_sel", 32'(cap_sel), 32'd3);
    check("cold_mru", 32'(cap_mru), 32'd3);
    check("cold_set_dirty", 32'(cap_sd), 32'd0);
    check("cold_miss_cnt", 32'(miss_cnt), 32'd1);

    // Dirty eviction of LRU way 6.
    access(8'h00, 8'hFF, 8'h40, 3'd6, 1'b0, 1'b1);
    check("dirty_wr_cycles", 32'(cap_wr), 32'd4);
    check("dirty_rd_cycles", 32'(cap_rd), 32'd4);
    check("dirty_overlap", 32'(cap_ovl), 32'd0);
    check("dirty_way_sel", 32'(cap_sel), 32'd6);
    check("dirty_wb_cnt", 32'(wb_cnt), 32'd1);
    check("dirty_miss_cnt", 32'(miss_cnt), 32'd2);

    // Reset during a fill.
    fixed_delay = 20;
    @(negedge clk);
    hit = 0; valid = 0; dirty = 0; lru_idx = 0; cpu_write = 0; cpu_req = 1'b1;
    for (int c = 0; c < 10 && !mem_read; c++) begin
      @(posedge clk);
      #1;
    end
    check("fill_started", 32'(mem_read), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_cpu_resp", 32'(cpu_resp), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0;

    // Multi-hit: lowest index wins.
    fixed_delay = 0;
    access(8'b1001_0000, 8'hFF, 8'h00, 3'd1, 1'b0, 1'b0);
    check("multi_hit_sel", 32'(cap_sel), 32'd4);
    check("multi_hit_mru", 32'(cap_mru), 32'd4);
    check("multi_hit_latency", 32'(cap_cyc), 32'd1);

    // Counter wrap with a 4-bit miss counter.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      access(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      if (i == 14) check("miss_cnt_15", 32'(miss_cnt), 32'd15);
    end
    check("miss_cnt_wrap", 32'(miss_cnt), 32'd0);

    // Randomized traffic with random memory latency and spurious responses.
    rand_mode = 1;
    fixed_delay = -1;
    for (int n = 0; n < 300; n++) begin
      logic [7:0] h, v;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      h = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
      v = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
      access(h, v, 8'($urandom), 3'($urandom), 1'($urandom), 1'b1);
      if (h != 0) check("rand_hit_latency", 32'(cap_cyc), 32'd1);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
